mic_frame_tx: RTL and testbench



---
 rtl/mic_frame_tx.sv | 164 ++++++++++++++++
 tb/tb_mic_frame_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_frame_tx.sv
// mic_frame_tx: drains one frame of mic bytes from the capture FIFO and emits
// it as an Ethernet II frame (preamble .. FCS) on a byte-wide GMII-style port.
module mic_frame_tx #(
  parameter int          PAYLOAD_LEN = 1200,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          IFG_LEN     = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fullEn,
  input  logic [7:0] data,
  output logic       enable,
  output logic [7:0] txData,
  output logic       txEn,
  output logic       busy
);

  localparam logic [10:0] PAY_LAST = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0] RD_LIM   = 11'(PAYLOAD_LEN - 2);
  localparam logic [10:0] IFG_LAST = 11'(IFG_LEN - 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, DST, SRC, TYPE, SEQ, PAY, FCS, IFG
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        enable_q, enable_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q, busy_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_upd;
  logic [31:0] fcs_src;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
    case (i)
      3'd0:    return m[47:40];
      3'd1:    return m[39:32];
      3'd2:    return m[31:24];
      3'd3:    return m[23:16];
      3'd4:    return m[15:8];
      default: return m[7:0];
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: cnt_q indexes the byte within the current field
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fullEn) state_d = PRE;
      end
      PRE:  if (cnt_q == 11'd6) begin state_d = SFD; cnt_d = '0; end
      SFD:  begin state_d = DST; cnt_d = '0; end
      DST:  if (cnt_q == 11'd5) begin state_d = SRC; cnt_d = '0; end
      SRC:  if (cnt_q == 11'd5) begin state_d = TYPE; cnt_d = '0; end
      TYPE: if (cnt_q == 11'd1) begin state_d = SEQ; cnt_d = '0; end
      SEQ:  if (cnt_q == 11'd1) begin state_d = PAY; cnt_d = '0; end
      PAY:  if (cnt_q == PAY_LAST) begin state_d = FCS; cnt_d = '0; end
      FCS:  if (cnt_q == 11'd3) begin state_d = IFG; cnt_d = '0; end
      IFG:  if (cnt_q == IFG_LAST) begin state_d = IDLE; cnt_d = '0; end
      default: begin state_d = IDLE; cnt_d = '0; end
    endcase
  end

  // outputs are computed for the upcoming cycle, so they decode state_d/cnt_d
  always_comb begin
    tx_data_d = 8'h00;
    tx_en_d   = 1'b0;
    enable_d  = 1'b0;
    busy_d    = (state_d != IDLE);
    seq_d     = seq_q;
    crc_upd   = crc_step(crc_q, tx_data_q);
    crc_d     = crc_q;
    // first FCS byte is emitted while the last payload byte is still being folded in
    fcs_src   = (cnt_d == '0) ? ~crc_upd : ~crc_q;

    if (state_q == IDLE) crc_d = '1;
    else if (state_q inside {DST, SRC, TYPE, SEQ, PAY}) crc_d = crc_upd;

    if (state_q == FCS && cnt_q == 11'd3) seq_d = seq_q + 16'd1;

    case (state_d)
      PRE:  begin tx_en_d = 1'b1; tx_data_d = 8'h55; end
      SFD:  begin tx_en_d = 1'b1; tx_data_d = 8'hD5; end
      DST:  begin tx_en_d = 1'b1; tx_data_d = mac_byte(DST_MAC, cnt_d[2:0]); end
      SRC:  begin tx_en_d = 1'b1; tx_data_d = mac_byte(SRC_MAC, cnt_d[2:0]); end
      TYPE: begin
        tx_en_d   = 1'b1;
        tx_data_d = cnt_d[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
      end
      SEQ: begin
        tx_en_d   = 1'b1;
        enable_d  = 1'b1;
        tx_data_d = cnt_d[0] ? seq_q[7:0] : seq_q[15:8];
      end
      PAY: begin
        // reads run two cycles ahead of the byte on the wire
        tx_en_d   = 1'b1;
        enable_d  = (cnt_d < RD_LIM);
        tx_data_d = data;
      end
      FCS: begin
        tx_en_d = 1'b1;
        case (cnt_d[1:0])
          2'd0:    tx_data_d = fcs_src[7:0];
          2'd1:    tx_data_d = fcs_src[15:8];
          2'd2:    tx_data_d = fcs_src[23:16];
          default: tx_data_d = fcs_src[31:24];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q  <= 1'b0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      seq_q     <= 16'h0000;
      crc_q     <= 32'hFFFFFFFF;
    end else begin
      enable_q  <= enable_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      seq_q     <= seq_d;
      crc_q     <= crc_d;
    end
  end

  assign enable = enable_q;
  assign txData = tx_data_q;
  assign txEn   = tx_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mic_frame_tx.sv
// Directed bench for mic_frame_tx with a 46-byte payload and a counting FIFO model.
module tb_mic_frame_tx;
  localparam int N   = 46;
  localparam int IFG = 12;
  localparam int FL  = N + 28;

  logic       clk = 1'b0;
  logic       reset, fullEn, fifo_clr;
  logic [7:0] data;
  logic       enable, txEn, busy;
  logic [7:0] txData;
  logic [7:0] rd_ptr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] fr [0:FL+15];
  logic [7:0] ex [0:FL-1];
  int f_len, f_en, f_en_first, f_start, f_ifg_err;
  bit f_contig, f_busy_after, f_found;

  mic_frame_tx #(.PAYLOAD_LEN(N), .IFG_LEN(IFG)) dut (
    .clk(clk), .reset(reset), .fullEn(fullEn), .data(data),
    .enable(enable), .txData(txData), .txEn(txEn), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read, byte value = read index
  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= 8'h00;
    else if (enable) begin
      data   <= rd_ptr;
      rd_ptr <= rd_ptr + 8'h01;
    end
  end

  function automatic logic [31:0] crc_b(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_exp(input logic [15:0] seq, input logic [7:0] pstart);
    logic [31:0] c;
    for (int i = 0; i < 7; i++) ex[i] = 8'h55;
    ex[7] = 8'hD5;
    for (int i = 8; i < 14; i++) ex[i] = 8'hFF;
    ex[14] = 8'h02; ex[15] = 8'h00; ex[16] = 8'h00;
    ex[17] = 8'h00; ex[18] = 8'h00; ex[19] = 8'h01;
    ex[20] = 8'h88; ex[21] = 8'hB5;
    ex[22] = seq[15:8]; ex[23] = seq[7:0];
    for (int k = 0; k < N; k++) ex[24+k] = pstart + 8'(k);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 24 + N; i++) c = crc_b(c, ex[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) ex[24+N+i] = 8'(c >> (8 * i));
  endtask

  function automatic int frame_diff();
    for (int i = 0; i < FL; i++) if (fr[i] !== ex[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] residue();
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int i = 8; i < FL; i++) r = crc_b(r, fr[i]);
    return r;
  endfunction

  // Samples one frame at negedges; optionally drops fullEn or injects reset at byte t.
  task automatic capture(input int drop_t, input int rst_t, output bit aborted);
    int w, last_en;
    w = 0; last_en = -2; aborted = 0;
    f_len = 0; f_en = 0; f_en_first = -1; f_contig = 1; f_ifg_err = 0;
    f_found = 0; f_busy_after = 1;
    while (txEn !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    if (txEn !== 1'b1) return;
    f_found = 1;
    f_start = cyc;
    while (txEn === 1'b1 && f_len < FL + 10) begin
      fr[f_len] = txData;
      if (enable === 1'b1) begin
        if (f_en_first < 0) f_en_first = f_len;
        else if (last_en != f_len - 1) f_contig = 0;
        last_en = f_len;
        f_en++;
      end
      if (f_len == drop_t) fullEn = 1'b0;
      if (f_len == rst_t) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        aborted = 1;
        return;
      end
      f_len++;
      @(negedge clk);
    end
    for (int i = 0; i < IFG; i++) begin
      if (busy !== 1'b1 || enable !== 1'b0 || txEn !== 1'b0) f_ifg_err++;
      @(negedge clk);
    end
    f_busy_after = busy;
  endtask

  task automatic do_reset();
    reset = 1'b1; fifo_clr = 1'b1;
    @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic pulse_full();
    fullEn = 1'b1;
    @(negedge clk);
    fullEn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fullEn = 1'b1; fifo_clr = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (txEn !== 1'b0) begin bad++; $display("FAIL rst_txen got=%b want=0", txEn); end
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", enable); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (txData !== 8'h00) begin bad++; $display("FAIL rst_txdata got=%h want=00", txData); end
    reset = 1'b0; fullEn = 1'b0; fifo_clr = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_full_together got=%b want=0", busy); end
  endtask

  task automatic test_idle();
    int viol;
    viol = 0;
    do_reset();
    repeat (1000) begin
      @(negedge clk);
      if (enable !== 1'b0 || txEn !== 1'b0 || busy !== 1'b0 || txData !== 8'h00) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL idle_quiet got=%0d active cycles want=0", viol); end
  endtask

  task automatic test_single();
    bit ab;
    int d, act;
    logic [31:0] r;
    fifo_clr = 1'b1; @(negedge clk); fifo_clr = 1'b0;
    pulse_full();
    capture(-1, -1, ab);
    total++; if (!f_found) begin bad++; $display("FAIL single_start got=none want=frame"); end
    total++; if (f_len !== FL) begin bad++; $display("FAIL single_txen_len got=%0d want=%0d", f_len, FL); end
    total++; if (f_en !== N) begin bad++; $display("FAIL single_en_cnt got=%0d want=%0d", f_en, N); end
    total++; if (f_en_first !== 22) begin bad++; $display("FAIL single_en_first got=%0d want=22", f_en_first); end
    total++; if (f_contig !== 1'b1) begin bad++; $display("FAIL single_en_contig got=0 want=1"); end
    build_exp(16'h0000, 8'h00);
    d = frame_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL single_bytes idx=%0d got=%h want=%h", d, fr[d], ex[d]); end
    r = residue();
    total++; if (r !== 32'hDEBB20E3) begin bad++; $display("FAIL single_residue got=%h want=debb20e3", r); end
    total++; if (f_ifg_err !== 0) begin bad++; $display("FAIL single_ifg got=%0d bad cycles want=0", f_ifg_err); end
    total++; if (f_busy_after !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", f_busy_after); end
    act = 0;
    repeat (40) begin @(negedge clk); if (txEn !== 1'b0 || enable !== 1'b0) act++; end
    total++; if (act !== 0) begin bad++; $display("FAIL single_no_restart got=%0d want=0", act); end
  endtask

  task automatic test_back_to_back();
    bit ab;
    int d, prev;
    do_reset();
    fullEn = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      capture(-1, -1, ab);
      if (k == 2) fullEn = 1'b0;
      total++; if (f_en !== N) begin bad++; $display("FAIL b2b_en_cnt frame=%0d got=%0d want=%0d", k, f_en, N); end
      total++;
      if (fr[22] !== 8'h00 || fr[23] !== 8'(k)) begin
        bad++; $display("FAIL b2b_seq frame=%0d got=%h%h want=00%h", k, fr[22], fr[23], 8'(k));
      end
      build_exp(16'(k), 8'(N * k));
      d = frame_diff();
      total++; if (d !== -1) begin bad++; $display("FAIL b2b_bytes frame=%0d idx=%0d got=%h want=%h", k, d, fr[d], ex[d]); end
      if (k > 0) begin
        total++;
        if (f_start - prev !== FL + IFG + 1) begin
          bad++; $display("FAIL b2b_spacing frame=%0d got=%0d want=%0d", k, f_start - prev, FL + IFG + 1);
        end
      end
      prev = f_start;
    end
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop got=%b want=0", busy); end
  endtask

  task automatic test_fullen_drop();
    bit ab;
    int d, act;
    do_reset();
    fullEn = 1'b1;
    capture(30, -1, ab);
    total++; if (f_en !== N) begin bad++; $display("FAIL drop_en_cnt got=%0d want=%0d", f_en, N); end
    build_exp(16'h0000, 8'h00);
    d = frame_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL drop_bytes idx=%0d got=%h want=%h", d, fr[d], ex[d]); end
    act = 0;
    repeat (60) begin @(negedge clk); if (txEn !== 1'b0 || busy !== 1'b0) act++; end
    total++; if (act !== 0) begin bad++; $display("FAIL drop_no_restart got=%0d want=0", act); end
  endtask

  task automatic test_mid_reset();
    bit ab;
    int d;
    do_reset();
    pulse_full();
    capture(-1, -1, ab);
    pulse_full();
    capture(-1, 40, ab);
    total++; if (ab !== 1'b1) begin bad++; $display("FAIL mreset_reached got=0 want=1"); end
    total++;
    if (txEn !== 1'b0 || enable !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mreset_outputs got=%b%b%b want=000", txEn, enable, busy);
    end
    fifo_clr = 1'b1; @(negedge clk); fifo_clr = 1'b0;
    pulse_full();
    capture(-1, -1, ab);
    build_exp(16'h0000, 8'h00);
    d = frame_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL mreset_next idx=%0d got=%h want=%h", d, fr[d], ex[d]); end
  endtask

  task automatic test_seq_wrap();
    bit ab;
    int d;
    do_reset();
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    pulse_full();
    capture(-1, -1, ab);
    total++; if (fr[22] !== 8'hFF || fr[23] !== 8'hFF) begin bad++; $display("FAIL wrap_ffff got=%h%h want=ffff", fr[22], fr[23]); end
    build_exp(16'hFFFF, 8'h00);
    d = frame_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL wrap_bytes idx=%0d got=%h want=%h", d, fr[d], ex[d]); end
    pulse_full();
    capture(-1, -1, ab);
    total++; if (fr[22] !== 8'h00 || fr[23] !== 8'h00) begin bad++; $display("FAIL wrap_0000 got=%h%h want=0000", fr[22], fr[23]); end
    build_exp(16'h0000, 8'(N));
    d = frame_diff();
    total++; if (d !== -1) begin bad++; $display("FAIL wrap_next_bytes idx=%0d got=%h want=%h", d, fr[d], ex[d]); end
  endtask

  initial begin
    reset = 1'b1; fullEn = 1'b0; fifo_clr = 1'b1;
    @(negedge clk);
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_fullen_drop();
    test_mid_reset();
    test_seq_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
